// File: rtl/mipi_tx_raw_packer.sv
// mipi_tx_raw_packer: packs groups of four 12-bit pixels into a RAW10 or RAW12
// CSI-2 byte stream and emits it as 32-bit, 4-lane beats with a byte-keep mask.
// A 16-byte ordered buffer decouples pixel acceptance from beat consumption.
module mipi_tx_raw_packer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  packet_type_i,
  input  logic        pixel_valid_i,
  input  logic [47:0] pixel_i,
  input  logic        pixel_last_i,
  output logic        pixel_ready_o,
  output logic        data_valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  data_keep_o,
  output logic        data_last_o,
  input  logic        data_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        raw10_q, raw10_d;
  logic        ready_en_q;

  logic [7:0]  buf_byte [16];
  logic [7:0]  grp_byte [8];

  logic        cur_raw10;
  logic [4:0]  grp_len;
  logic [4:0]  app_len;
  logic [4:0]  remain;
  logic [2:0]  removed;
  logic        accept;
  logic        xfer;

  logic [11:0] p1, p2, p3, p4;

  assign p1 = pixel_i[47:36];
  assign p2 = pixel_i[35:24];
  assign p3 = pixel_i[23:12];
  assign p4 = pixel_i[11:0];

  // Packing width: follow the type input while idle, the latched type once a packet is open.
  always_comb begin
    cur_raw10 = (state_q == ST_IDLE) ? (packet_type_i == 3'b011) : raw10_q;
    grp_len   = cur_raw10 ? 5'd5 : 5'd6;
  end

  // Handshake and beat qualifiers, decoded from registered state only.
  always_comb begin
    pixel_ready_o = ready_en_q && (state_q != ST_FLUSH) && (cnt_q <= (5'd16 - grp_len));
    data_valid_o  = (cnt_q >= 5'd4) || ((state_q == ST_FLUSH) && (cnt_q != 5'd0));
    data_last_o   = (state_q == ST_FLUSH) && (cnt_q <= 5'd4) && (cnt_q != 5'd0);
    if (cnt_q >= 5'd4) begin
      data_keep_o = 4'b1111;
    end else begin
      case (cnt_q[1:0])
        2'd0:    data_keep_o = 4'b0000;
        2'd1:    data_keep_o = 4'b0001;
        2'd2:    data_keep_o = 4'b0011;
        default: data_keep_o = 4'b0111;
      endcase
    end
  end

  genvar gi;

  // Lane bytes come straight from the buffer head; empty lanes read as zero.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign data_o[8*gi +: 8] = data_keep_o[gi] ? buf_byte[gi] : 8'h00;
    end
  endgenerate

  // Occupancy bookkeeping: bytes leaving with a beat, bytes arriving with a group.
  always_comb begin
    accept  = pixel_valid_i && pixel_ready_o;
    xfer    = data_valid_o && data_ready_i;
    removed = 3'd0;
    if (xfer) begin
      removed = (cnt_q >= 5'd4) ? 3'd4 : cnt_q[2:0];
    end
    remain  = cnt_q - {2'b00, removed};
    app_len = accept ? grp_len : 5'd0;
    cnt_d   = remain + app_len;
  end

  // Byte layout of one pixel group in stream order.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      grp_byte[i] = 8'h00;
    end
    grp_byte[0] = p1[11:4];
    grp_byte[1] = p2[11:4];
    if (cur_raw10) begin
      grp_byte[2] = p3[11:4];
      grp_byte[3] = p4[11:4];
      grp_byte[4] = {p4[3:2], p3[3:2], p2[3:2], p1[3:2]};
    end else begin
      grp_byte[2] = {p2[3:0], p1[3:0]};
      grp_byte[3] = p3[11:4];
      grp_byte[4] = p4[11:4];
      grp_byte[5] = {p4[3:0], p3[3:0]};
    end
  end

  // Packet framing: open on first group, flush after the last group, close on last beat.
  always_comb begin
    state_d = state_q;
    raw10_d = raw10_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          raw10_d = cur_raw10;
          state_d = pixel_last_i ? ST_FLUSH : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (accept && pixel_last_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (xfer && data_last_o) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; ready is held off until the first clock after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      raw10_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raw10_q    <= raw10_d;
      ready_en_q <= 1'b1;
    end
  end

  // Buffer slots: keep surviving bytes shifted to the head, then append the new group.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam logic [4:0] POS = 5'(gi);
      logic [7:0] byte_d, byte_q;
      logic [3:0] src_idx;
      logic [2:0] app_idx;

      // Select the byte that lands in this slot next cycle.
      always_comb begin
        src_idx = 4'(POS) + {1'b0, removed};
        app_idx = 3'(POS - remain);
        byte_d  = 8'h00;
        if (POS < remain) begin
          byte_d = buf_byte[src_idx];
        end else if ((POS - remain) < app_len) begin
          byte_d = grp_byte[app_idx];
        end
      end

      // Slot storage, cleared on reset so no stale byte survives.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          byte_q <= 8'h00;
        end else begin
          byte_q <= byte_d;
        end
      end

      assign buf_byte[gi] = byte_q;
    end
  endgenerate

endmodule
